// File: rtl/nr_div_pkg.sv
// rtl/nr_div_pkg.sv - shared FSM state encoding and constants for the non-restoring divider.
package nr_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest operand the divide-by-zero constant can describe.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] dbz_quotient(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// rtl/nr_div_step.sv - one combinational non-restoring iteration: shift {A,Q}, add/sub M, new quotient bit.
module nr_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_a_sh;
  logic [WIDTH:0] w_m_ext;

  assign w_a_sh  = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_m_ext = {1'b0, i_m};

  // The add/subtract choice follows the sign of A before the shift.
  assign o_a = i_a[WIDTH] ? (w_a_sh + w_m_ext) : (w_a_sh - w_m_ext);
  assign o_q = {i_q[WIDTH-2:0], ~o_a[WIDTH]};

endmodule

// File: rtl/nr_divider_pipe_ctl.sv
// rtl/nr_divider_pipe_ctl.sv - handshaked iterative non-restoring divider, one quotient bit per cycle.
// Optional signed operation is enabled by defining NR_DIVIDER_SIGNED_EN.
module nr_divider_pipe_ctl
  import nr_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef NR_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_step_a;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_dbz_q;
  logic             w_accept;
  logic             w_div_zero;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_div_zero = (divisor == '0);
  assign w_dbz_q    = WIDTH'(dbz_quotient(WIDTH));
  assign w_rem_mag  = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m) : r_a[WIDTH-1:0];

`ifdef NR_DIVIDER_SIGNED_EN
  logic r_q_neg;
  logic r_r_neg;
  logic w_dvd_neg;
  logic w_dvs_neg;

  assign w_dvd_neg = signed_op && dividend[WIDTH-1];
  assign w_dvs_neg = signed_op && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;
  // Truncating division: quotient sign from the operand signs, remainder follows the dividend.
  assign w_quo_fin = r_q_neg ? (~r_q + 1'b1) : r_q;
  assign w_rem_fin = r_r_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept) begin
      r_q_neg <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg <= w_dvd_neg;
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_quo_fin = r_q;
  assign w_rem_fin = w_rem_mag;
`endif

  nr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_a(r_a),
    .i_q(r_q),
    .i_m(r_m),
    .o_a(w_step_a),
    .o_q(w_step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = w_div_zero ? DONE : RUN;
      RUN:  if (r_count == CNT_W'(1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m     <= w_dvs_mag;
            r_q     <= w_dvd_mag;
            r_a     <= '0;
            r_count <= CNT_W'(WIDTH);
            if (w_div_zero) begin
              r_out_valid <= 1'b1;
              r_quotient  <= w_dbz_q;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end
          end
        end
        RUN: begin
          r_a     <= w_step_a;
          r_q     <= w_step_q;
          r_count <= r_count - CNT_W'(1);
        end
        FIX: begin
          r_a         <= r_a[WIDTH] ? (r_a + {1'b0, r_m}) : r_a;
          r_out_valid <= 1'b1;
          r_quotient  <= w_quo_fin;
          r_remainder <= w_rem_fin;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_nr_divider_pipe_ctl.sv
// tb/tb_nr_divider_pipe_ctl.sv - directed self-checking bench for nr_divider_pipe_ctl.
module tb_nr_divider_pipe_ctl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
`ifdef NR_DIVIDER_SIGNED_EN
  logic         signed_op;
`endif

  int total = 0;
  int bad   = 0;

  nr_divider_pipe_ctl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
`ifdef NR_DIVIDER_SIGNED_EN
    .signed_op(signed_op),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1; 0 means no result within the budget.
  task automatic wait_result(output int lat, output bit ready_seen);
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dividend = '0;
    divisor = '0;
`ifdef NR_DIVIDER_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (quotient !== 16'h0) begin bad++; $display("FAIL reset_quotient: got %h want 0000", quotient); end
    total++; if (remainder !== 16'h0) begin bad++; $display("FAIL reset_remainder: got %h want 0000", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    bit rs;
    start_op(16'd100, 16'd7);
    wait_result(lat, rs);
    total++; if (lat != 18) begin bad++; $display("FAIL basic_latency: got %0d want 18", lat); end
    total++; if (quotient !== 16'd14) begin bad++; $display("FAIL basic_quotient: got %0d want 14", quotient); end
    total++; if (remainder !== 16'd2) begin bad++; $display("FAIL basic_remainder: got %0d want 2", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_retire: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit rs;
    start_op(16'hFFFF, 16'h0001);
    wait_result(lat, rs);
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL b2b1_in_ready_busy: got %b want 0", rs); end
    total++; if (quotient !== 16'hFFFF || remainder !== 16'h0) begin bad++; $display("FAIL b2b1_result: got %h/%h want ffff/0000", quotient, remainder); end
    @(posedge clk); #1;
    start_op(16'h0005, 16'h0009);
    wait_result(lat, rs);
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL b2b2_in_ready_busy: got %b want 0", rs); end
    total++; if (quotient !== 16'h0 || remainder !== 16'h5) begin bad++; $display("FAIL b2b2_result: got %h/%h want 0000/0005", quotient, remainder); end
    total++; if (lat != 18) begin bad++; $display("FAIL b2b2_latency: got %0d want 18", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_by_zero;
    int lat;
    bit rs;
    start_op(16'd1234, 16'd0);
    wait_result(lat, rs);
    total++; if (lat != 1) begin bad++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL dbz_quotient: got %h want ffff", quotient); end
    total++; if (remainder !== 16'd1234) begin bad++; $display("FAIL dbz_remainder: got %0d want 1234", remainder); end
    @(posedge clk); #1;
    total++; if (div_by_zero !== 1'b0 || quotient !== 16'h0) begin bad++; $display("FAIL dbz_clear: got dbz=%b q=%h want 0/0000", div_by_zero, quotient); end
  endtask

  task automatic test_backpressure;
    int lat;
    bit rs;
    bit stable;
    out_ready = 1'b0;
    start_op(16'd500, 16'd3);
    wait_result(lat, rs);
    total++; if (quotient !== 16'd166 || remainder !== 16'd2) begin bad++; $display("FAIL bp_result: got %0d/%0d want 166/2", quotient, remainder); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || quotient !== 16'd166 || remainder !== 16'd2 || in_ready !== 1'b0) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_stable: got %b want 1", stable); end
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_before_handshake: got %b want 0", in_ready); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_ready_after_handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    bit rs;
    bit seen;
    start_op(16'd1000, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_result: got %b want 0", seen); end
    start_op(16'd9, 16'd4);
    wait_result(lat, rs);
    total++; if (quotient !== 16'd2 || remainder !== 16'd1) begin bad++; $display("FAIL abort_next_result: got %0d/%0d want 2/1", quotient, remainder); end
    total++; if (lat != 18) begin bad++; $display("FAIL abort_next_latency: got %0d want 18", lat); end
    @(posedge clk); #1;
  endtask

`ifdef NR_DIVIDER_SIGNED_EN
  task automatic test_signed;
    int lat;
    bit rs;
    signed_op = 1'b1;
    start_op(16'hFF9C, 16'd7);
    wait_result(lat, rs);
    total++; if (quotient !== 16'hFFF2 || remainder !== 16'hFFFE) begin bad++; $display("FAIL signed_neg100_7: got %h/%h want fff2/fffe", quotient, remainder); end
    total++; if (lat != 18) begin bad++; $display("FAIL signed_latency: got %0d want 18", lat); end
    @(posedge clk); #1;
    start_op(16'h8000, 16'hFFFF);
    wait_result(lat, rs);
    total++; if (quotient !== 16'h8000 || remainder !== 16'h0) begin bad++; $display("FAIL signed_minneg: got %h/%h want 8000/0000", quotient, remainder); end
    @(posedge clk); #1;
    signed_op = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_run();
`ifdef NR_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
